uart_msg_tx_ctrl: RTL and testbench

UART_MSG_TX_CTRL -- requirements
Module: uart_msg_tx_ctrl

---
 rtl/uart_msg_tx_ctrl_if.sv | 28 ++
 rtl/uart_msg_tx_ctrl.sv | 115 +++++++++++
 tb/tb_uart_msg_tx_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_tx_ctrl_if.sv
// uart_msg_tx_ctrl_if: command, buffer-read and UART byte stream signals of the message transmit controller
//   master = controller side, slave = message core / buffer / transmitter side
//   start, req_len -> cmd_valid, cmd_len; msg_valid, msg_len; rd_addr -> rd_data (1-cycle read);
//   tx_data, tx_valid, tx_ready; busy, done
interface uart_msg_tx_ctrl_if #(parameter int WIDTH = 8, parameter int LEN = 256);
  localparam int AW = $clog2(LEN) + 1;
  logic start;
  logic [AW-1:0] req_len;
  logic cmd_valid;
  logic [AW-1:0] cmd_len;
  logic msg_valid;
  logic [AW-1:0] msg_len;
  logic [AW-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic busy;
  logic done;
  modport master (
    input start, req_len, msg_valid, msg_len, rd_data, tx_ready,
    output cmd_valid, cmd_len, rd_addr, tx_data, tx_valid, busy, done
  );
  modport slave (
    output start, req_len, msg_valid, msg_len, rd_data, tx_ready,
    input cmd_valid, cmd_len, rd_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/uart_msg_tx_ctrl.sv
// uart_msg_tx_ctrl: requests a message, then streams its buffer bytes to a UART transmitter
//   clk, rst (sync, active-high); bus = uart_msg_tx_ctrl_if.master
//   Optional: define UART_MSG_CHECKSUM_EN to append the XOR of all sent bytes after a non-empty message
module uart_msg_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN = 256
) (
  input logic clk,
  input logic rst,
  uart_msg_tx_ctrl_if.master bus
);
  localparam int AW = $clog2(LEN) + 1;
  typedef enum logic [2:0] {IDLE, CMD, WAIT_MSG, RD, RD_WAIT, TX, CKSUM, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cmd_len_q, cmd_len_d, len_q, len_d, idx_q, idx_d, rd_addr_q, idx_inc;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d, cmd_valid_q, busy_q, done_q;
`ifdef UART_MSG_CHECKSUM_EN
  logic [WIDTH-1:0] cks_q, cks_d;
`endif
  always_comb begin
    state_d = state_q;
    cmd_len_d = cmd_len_q;
    len_d = len_q;
    idx_d = idx_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    idx_inc = idx_q + AW'(1);
`ifdef UART_MSG_CHECKSUM_EN
    cks_d = cks_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        cmd_len_d = bus.req_len;
        state_d = CMD;
      end
      CMD: state_d = WAIT_MSG;
      WAIT_MSG: if (bus.msg_valid) begin
        len_d = bus.msg_len;
        idx_d = '0;
`ifdef UART_MSG_CHECKSUM_EN
        cks_d = '0;
`endif
        state_d = bus.msg_len == '0 ? DONE : RD;
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        tx_data_d = bus.rd_data;
        tx_valid_d = 1'b1;
`ifdef UART_MSG_CHECKSUM_EN
        cks_d = cks_q ^ bus.rd_data;
`endif
        state_d = TX;
      end
      TX: if (bus.tx_ready) begin
        idx_d = idx_inc;
        tx_valid_d = 1'b0;
        state_d = idx_inc < len_q ? RD : DONE;
`ifdef UART_MSG_CHECKSUM_EN
        if (idx_inc >= len_q) begin
          tx_data_d = cks_q;
          tx_valid_d = 1'b1;
          state_d = CKSUM;
        end
`endif
      end
`ifdef UART_MSG_CHECKSUM_EN
      CKSUM: if (bus.tx_ready) begin
        tx_valid_d = 1'b0;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // rd_addr simply tracks idx, so it equals idx whenever the FSM sits in RD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_len_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      rd_addr_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_MSG_CHECKSUM_EN
      cks_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_len_q <= cmd_len_d;
      len_q <= len_d;
      idx_q <= idx_d;
      rd_addr_q <= idx_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_valid_q <= state_d == CMD;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
`ifdef UART_MSG_CHECKSUM_EN
      cks_q <= cks_d;
`endif
    end
  end
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_len = cmd_len_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_uart_msg_tx_ctrl.sv
// tb_uart_msg_tx_ctrl: randomized self-checking bench for uart_msg_tx_ctrl against a byte-queue reference model
module tb_uart_msg_tx_ctrl;
  localparam int WIDTH = 8;
  localparam int LEN = 256;
  localparam int AW = $clog2(LEN) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  int cmd_cnt = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int first_tx = -1;
  int done_at = -1;
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  logic [7:0] prev_d = '0;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  uart_msg_tx_ctrl_if #(.WIDTH(WIDTH), .LEN(LEN)) bus ();
  uart_msg_tx_ctrl #(.WIDTH(WIDTH), .LEN(LEN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr[7:0]];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst) prev_v = 1'b0;
    else begin
      if (bus.cmd_valid) cmd_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (bus.tx_valid && first_tx < 0) first_tx = cyc;
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(bus.tx_valid), 1);
        check("hold_data", 32'(bus.tx_data), 32'(prev_d));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        check("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        xfer_cnt++;
      end
      prev_v = bus.tx_valid;
      prev_r = bus.tx_ready;
      prev_d = bus.tx_data;
    end
  end
  task automatic run_msg(input int len, input int d, input int m, input int abort_at);
    int t0, msg_at, c0, n0, nb;
    logic [AW-1:0] rl;
    logic [7:0] x;
    logic seen;
    mode = m;
    xfer_cnt = 0;
    first_tx = -1;
    exp_q.delete();
    c0 = cmd_cnt;
    n0 = done_cnt;
    rl = AW'($urandom_range(0, LEN));
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.req_len = rl;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.req_len = '0;
    @(negedge clk);
    #1;
    check("cmd_valid", 32'(bus.cmd_valid), 1);
    check("cmd_len", 32'(bus.cmd_len), 32'(rl));
    check("busy", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    repeat (d) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.msg_len = AW'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.msg_valid = 1'b1;
    bus.msg_len = AW'(len);
    msg_at = cyc;
    x = '0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[8'(i)]);
      x ^= mem[8'(i)];
    end
`ifdef UART_MSG_CHECKSUM_EN
    if (len != 0) exp_q.push_back(x);
`endif
    nb = exp_q.size();
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
    bus.msg_len = '0;
    seen = 1'b0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (abort_at != 0 && xfer_cnt == abort_at) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_cmd_len", 32'(bus.cmd_len), 0);
        exp_q.delete();
        return;
      end
      seen = bus.done;
    end
    check("done_seen", 32'(seen), 1);
    check("cmd_pulses", cmd_cnt - c0, 1);
    check("done_pulses", done_cnt - n0, 1);
    check("bytes_sent", xfer_cnt, nb);
    check("queue_empty", exp_q.size(), 0);
    if (len == 0) begin
      check("done_latency", done_at - msg_at, 1);
      check("no_tx", first_tx, -1);
    end else check("first_latency", first_tx - t0, 5 + d);
    @(negedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 0);
    check("done_width", 32'(bus.done), 0);
  endtask
  initial begin
    string s;
    bus.start = 1'b0;
    bus.req_len = '0;
    bus.msg_valid = 1'b0;
    bus.msg_len = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_tx_valid", 32'(bus.tx_valid), 0);
    check("reset_cmd_valid", 32'(bus.cmd_valid), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_tx_data", 32'(bus.tx_data), 0);
    check("reset_cmd_len", 32'(bus.cmd_len), 0);
    check("reset_rd_addr", 32'(bus.rd_addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s = " 0~99\n\r";
    for (int i = 0; i < 7; i++) mem[i] = s[i];
    check("str_byte2", 32'(mem[2]), 32'h7e);
    run_msg(7, 3, 0, 0);
    run_msg(7, 2, 1, 0);
    run_msg(0, $urandom_range(0, 3), 2, 0);
    run_msg(7, 0, 0, 3);
    run_msg(7, 1, 0, 0);
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    mem[2] = 8'h04;
    run_msg(3, 0, 0, 0);
    run_msg(3, 2, 1, 0);
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_msg($urandom_range(0, 24), $urandom_range(0, 4), $urandom_range(0, 2), 0);
    end
    run_msg(12, 1, 2, $urandom_range(1, 10));
    run_msg(9, 0, 2, 0);
    run_msg(256, 1, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
